// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the staged reset sequencer.
// State encoding, parameter defaults and the counter-width helper live here.
package reset_seq_pkg;

  localparam int DEF_N_STAGES    = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 8;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_WAIT_ACK,
    S_GAP,
    S_RUN,
    S_FAULT
  } seq_state_t;

  // One shared counter serves every timed state, so it is sized for the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous clear.
// Brings the asynchronous PLL lock indication into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains, waits for PLL lock, then releases them one at a time
// in ascending order, waiting for each stage's ack and a gap before the next.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_HOLD      | all resets asserted, counting HOLD_CYCLES
// S_WAIT_LOCK | all resets asserted, waiting for synchronized lock
// S_RELEASE   | deassert reset of stage idx (single cycle)
// S_WAIT_ACK  | waiting for stage_ack[idx], bounded by ACK_TIMEOUT
// S_GAP       | idle GAP_CYCLES before the next stage is released
// S_RUN       | all stages released and acked, ready asserted
// S_FAULT     | ack timeout: flag error, reassert all, retry from HOLD
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                pll_locked,
  input  logic                sw_rst_req,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] rst_out_n,
  output logic                ready,
  output logic                error
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  seq_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [N_STAGES-1:0] rst_nxt;
  logic                ready_nxt, error_nxt;
  logic                lock_s, abort;

  sync_2ff u_lock_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (pll_locked),
    .q      (lock_s)
  );

  // Lock is only required once it has been seen, so losing it matters after WAIT_LOCK.
  assign abort = sw_rst_req ||
                 (!lock_s && (state != S_HOLD) && (state != S_WAIT_LOCK));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_out_n <= '0;
      ready     <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      rst_out_n <= rst_nxt;
      ready     <= ready_nxt;
      error     <= error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_nxt   = rst_out_n;
    error_nxt = error;
    if (abort) begin
      state_nxt = S_HOLD;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rst_nxt   = '0;
    end else begin
      case (state)
        S_HOLD: begin
          rst_nxt = '0;
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = S_RELEASE;
            idx_nxt   = '0;
          end
        end
        S_RELEASE: begin
          rst_nxt[idx] = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // Timeout outranks an ack arriving on the same cycle.
          if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state_nxt = S_FAULT;
            cnt_nxt   = '0;
            rst_nxt   = '0;
            error_nxt = 1'b1;
          end else if (stage_ack[idx]) begin
            cnt_nxt   = '0;
            state_nxt = (idx == IDX_W'(N_STAGES - 1)) ? S_RUN : S_GAP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state_nxt = S_RELEASE;
            idx_nxt   = idx + IDX_W'(1);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          rst_nxt = '1;
        end
        S_FAULT: begin
          rst_nxt   = '0;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_HOLD;
        end
        default: begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          rst_nxt   = '0;
        end
      endcase
    end
  end

  // ready follows RUN by one cycle and drops on the edge that leaves RUN.
  assign ready_nxt = (state == S_RUN) && (state_nxt == S_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (3 stages, hold 4, gap 2, ack timeout 10).
// Expected edge numbers are hand-derived from the sequencing rules.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [2:0] stage_ack;
  logic [2:0] rst_out_n;
  logic       ready;
  logic       error;

  logic [2:0] ack_d = 3'b000;
  logic [2:0] ack_mask = 3'b111;

  int n_vec = 0;
  int n_bad = 0;
  int rise0, rise1, rise2, rise_rdy;

  reset_sequencer #(
    .N_STAGES    (3),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .ACK_TIMEOUT (10)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .stage_ack  (stage_ack),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Stage feedback echoes the reset outputs one cycle late.
  always @(posedge clk) ack_d <= rst_out_n;
  assign stage_ack = ack_d & ack_mask;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state_rst_out_n", int'(rst_out_n), 0);
    chk("rst_state_ready", int'(ready), 0);
    chk("rst_state_error", int'(error), 0);
    arst_n = 1'b1;
  endtask

  // Records, relative to the call point, the edge at which each output first rises.
  task automatic run_measure(input int n);
    rise0 = -1; rise1 = -1; rise2 = -1; rise_rdy = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (rst_out_n[0] && rise0 < 0) rise0 = k;
      if (rst_out_n[1] && rise1 < 0) rise1 = k;
      if (rst_out_n[2] && rise2 < 0) rise2 = k;
      if (ready && rise_rdy < 0) rise_rdy = k;
    end
  endtask

  task automatic chk_seq(input string tag, input int e0, input int e1, input int e2,
                         input int er);
    chk({tag, "_rise0"}, rise0, e0);
    chk({tag, "_rise1"}, rise1, e1);
    chk({tag, "_rise2"}, rise2, e2);
    chk({tag, "_ready"}, rise_rdy, er);
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    // Normal bring-up with lock already present.
    pll_locked = 1'b1;
    do_reset();
    run_measure(25);
    chk_seq("normal", 6, 11, 16, 19);
    chk("normal_rst_final", int'(rst_out_n), 7);
    chk("normal_error", int'(error), 0);

    // Acks dropping while running change nothing.
    ack_mask = 3'b000;
    repeat (5) @(negedge clk);
    chk("ackdrop_ready", int'(ready), 1);
    chk("ackdrop_rst", int'(rst_out_n), 7);
    ack_mask = 3'b111;
    @(negedge clk);

    // Software reset in RUN: immediate reassert, then a full repeat.
    sw_pulse();
    chk("swrst_rst", int'(rst_out_n), 0);
    chk("swrst_ready", int'(ready), 0);
    run_measure(20);
    chk_seq("swrst", 6, 11, 16, 19);

    // Software reset while holding restarts the hold count.
    sw_pulse();
    repeat (2) @(negedge clk);
    sw_pulse();
    run_measure(20);
    chk_seq("holdrestart", 6, 11, 16, 19);

    // Lock absent for 20 cycles after reset release.
    pll_locked = 1'b0;
    do_reset();
    repeat (20) @(negedge clk);
    chk("nolock_rst", int'(rst_out_n), 0);
    chk("nolock_ready", int'(ready), 0);
    pll_locked = 1'b1;
    run_measure(20);
    chk_seq("latelock", 4, 9, 14, 17);

    // Lock lost in the gap after stage 1 is acked.
    do_reset();
    repeat (13) @(negedge clk);
    chk("lockloss_pre", int'(rst_out_n), 3);
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    chk("lockloss_sync_delay", int'(rst_out_n), 3);
    @(negedge clk);
    chk("lockloss_reassert", int'(rst_out_n), 0);
    chk("lockloss_ready", int'(ready), 0);
    repeat (10) @(negedge clk);
    chk("lockloss_held", int'(rst_out_n), 0);
    pll_locked = 1'b1;
    run_measure(20);
    chk_seq("relock", 4, 9, 14, 17);

    // Stage 1 never acks: timeout, fault, sticky error, retry.
    ack_mask = 3'b101;
    do_reset();
    repeat (20) @(negedge clk);
    chk("timeout_pre_rst", int'(rst_out_n), 3);
    chk("timeout_pre_error", int'(error), 0);
    @(negedge clk);
    chk("timeout_rst", int'(rst_out_n), 0);
    chk("timeout_error", int'(error), 1);
    repeat (7) @(negedge clk);
    chk("retry_rise0", int'(rst_out_n), 1);
    repeat (7) @(negedge clk);
    chk("retry_waitack_rst", int'(rst_out_n), 3);
    chk("retry_error_sticky", int'(error), 1);
    chk("retry_ready", int'(ready), 0);

    // Asynchronous reset mid WAIT_ACK, checked before any clock edge.
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_rst", int'(rst_out_n), 0);
    chk("arst_ready", int'(ready), 0);
    chk("arst_error", int'(error), 0);
    @(negedge clk);
    arst_n = 1'b1;
    ack_mask = 3'b111;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_STAGES, 3, number of sequenced reset domains (1..8).
REQ-002 Parameter HOLD_CYCLES, 16, minimum clocks all resets stay asserted before release may begin (>=1).
REQ-003 Parameter GAP_CYCLES, 8, idle clocks between one stage's ack and the next stage's release (>=1).
REQ-004 Parameter ACK_TIMEOUT, 255, clocks allowed for a stage ack after its release (>=1).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 arst_n  input  1  reset, asynchronous, active-low.
REQ-007 pll_locked  input  1  asynchronous lock indication; synchronized internally.
REQ-008 sw_rst_req  input  1  synchronous single-cycle software reset request.
REQ-009 stage_ack  input  N_STAGES  per-stage synchronized reset-released feedback, high = stage out of reset.
REQ-010 rst_out_n  output  N_STAGES  per-stage reset, active-low, registered.
REQ-011 ready  output  1  high only when all stages are released and acked.
REQ-012 error  output  1  sticky ack-timeout flag.

Function
REQ-013 FSM states: HOLD, WAIT_LOCK, RELEASE, WAIT_ACK, GAP, RUN, FAULT; stage index idx in 0..N_STAGES-1.
REQ-014 HOLD: rst_out_n all 0, hold counter runs; after exactly HOLD_CYCLES clocks in HOLD -> WAIT_LOCK.
REQ-015 WAIT_LOCK: remain until synchronized lock = 1, then idx <= 0 -> RELEASE.
REQ-016 RELEASE: one cycle; rst_out_n[idx] <= 1 (lower stages stay 1); timeout counter cleared -> WAIT_ACK.
REQ-017 WAIT_ACK: stage_ack[idx]=1 -> RUN if idx=N_STAGES-1, else GAP; counter reaching ACK_TIMEOUT with no ack -> FAULT.
REQ-018 GAP: exactly GAP_CYCLES clocks, then idx <= idx+1 -> RELEASE.
REQ-019 RUN: ready=1; all rst_out_n=1; remain until an abort event.
REQ-020 FAULT: one cycle; error <= 1 (sticky until arst_n); rst_out_n all 0 -> HOLD (automatic retry).
REQ-021 Abort event = sw_rst_req=1 or synchronized lock falling to 0 in any state except HOLD; effect: next edge rst_out_n all 0, ready 0, -> HOLD, counters cleared.
REQ-022 Reassertion is simultaneous for all stages; release is strictly ascending idx order, never two stages in the same cycle.
REQ-023 Priority on same cycle: abort > timeout > ack.
REQ-024 stage_ack bits of stages not yet released are ignored; an ack that drops in RUN has no effect.
REQ-025 sw_rst_req during HOLD restarts the hold count from zero.
REQ-026 ready is registered and asserts the cycle after entering RUN state.
REQ-027 Counters sized by $clog2 of their parameter + 1; no wrap-around possible within any state.

Reset
REQ-028 arst_n low asynchronously forces: state HOLD, counters 0, idx 0, rst_out_n all 0, ready 0, error 0, synchronizer flops 0.
REQ-029 After arst_n deasserts, HOLD begins counting on the first clock edge; arst_n mid-sequence aborts it identically.

Structure
REQ-030 Package reset_seq_pkg holds the FSM state enum and default parameter constants.
REQ-031 pll_locked synchronizer is one sub-module, sync_2ff (two flops, async clear on arst_n); no other sub-modules.

Verification (N_STAGES=3, HOLD_CYCLES=4, GAP_CYCLES=2, ACK_TIMEOUT=10)
REQ-032 pll_locked=1, stage_ack echoes rst_out_n one cycle late -> rst_out_n 000 for >=4 clocks, then 001, 011, 111 with >=2 idle clocks between rises; ready=1 afterwards, error=0.
REQ-033 pll_locked held 0 for 20 cycles after arst_n release -> rst_out_n stays 000 and ready=0 until 2 clocks after lock rises, then normal sequence.
REQ-034 stage_ack[1] tied 0 -> FAULT after 10 clocks in WAIT_ACK; rst_out_n returns 000, error=1 and stays 1 across retries.
REQ-035 sw_rst_req pulse in RUN -> next edge rst_out_n=000, ready=0, full sequence repeats.
REQ-036 pll_locked drops during GAP of stage 1 -> all resets reasserted, sequence restarts from stage 0 after relock.
REQ-037 arst_n pulsed low mid-WAIT_ACK -> outputs 000/0/0 immediately without a clock edge; error cleared.
